// File: rtl/uart_mem_loader_if.sv
// Memory write bus and playback control registers driven by uart_mem_loader.
interface uart_mem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] range;

  modport master (output wr_enable, wr_addr, wr_data, step, range);
  modport slave  (input  wr_enable, wr_addr, wr_data, step, range);
endinterface

// File: rtl/uart_mem_loader.sv
// UART command loader: 8N1 RX parser writing a memory and step/range registers, ACK/NAK on TX.
// Optional power-up LFSR pattern fill of the whole memory when LFSR_INIT_EN is defined.
module uart_mem_loader #(
  parameter int CLK_DIV    = 868,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic              txd,
  output logic              busy,
  uart_mem_loader_if.master mem
);
  localparam int NA = (ADDR_WIDTH + 7) / 8;
  localparam int ND = DATA_WIDTH / 8;
  localparam int FW = 8 * ((NA > ND) ? NA : ND);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  localparam logic [7:0] OP_SET_ADDR  = 8'h01;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_SET_STEP  = 8'h03;
  localparam logic [7:0] OP_SET_RANGE = 8'h04;
  localparam logic [7:0] ACK          = 8'h06;
  localparam logic [7:0] NAK          = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ARGS, P_EXEC} p_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic                  rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_t             rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic                  byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;

  p_state_t              p_state_q, p_state_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [2:0]            arg_cnt_q, arg_cnt_d, need;
  logic [FW-1:0]         field_q, field_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, step_q, step_d, range_q, range_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d, busy_q, busy_d;

  logic                  enq, deq, enq_ok;
  logic [7:0]            enq_byte;
  logic                  resp_valid_q, resp_valid_d;
  logic [7:0]            resp_byte_q, resp_byte_d;

  tx_state_t             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [9:0]            tx_shift_q, tx_shift_d;
  logic                  txd_q, txd_d;

`ifdef LFSR_INIT_EN
  logic                  init_active_q, init_active_d;
  logic [15:0]           lfsr_q, lfsr_d;
`endif

  always_comb begin
    rx_meta_d    = rxd;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // A glitch that is gone by mid start bit is not a frame.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
    endcase

    p_state_d = p_state_q;
    opcode_d  = opcode_q;
    arg_cnt_d = arg_cnt_q;
    field_d   = field_q;
    ptr_d     = ptr_q;
    step_d    = step_q;
    range_d   = range_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    enq       = 1'b0;
    enq_byte  = ACK;
    need      = (opcode_q == OP_WRITE) ? 3'(ND) : 3'(NA);

`ifdef LFSR_INIT_EN
    init_active_d = init_active_q;
    lfsr_d        = lfsr_q;
    // Fill reuses the address pointer so it naturally ends back at 0.
    if (init_active_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = DATA_WIDTH'(lfsr_q);
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      ptr_d     = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == '1) init_active_d = 1'b0;
    end else
`endif
    if (frame_err_q) begin
      p_state_d = P_IDLE;
      enq       = 1'b1;
      enq_byte  = NAK;
    end else begin
      case (p_state_q)
        P_IDLE: begin
          if (byte_valid_q) begin
            case (rx_shift_q)
              OP_SET_ADDR, OP_WRITE, OP_SET_STEP, OP_SET_RANGE: begin
                opcode_d  = rx_shift_q;
                arg_cnt_d = '0;
                field_d   = '0;
                p_state_d = P_ARGS;
              end
              default: begin
                enq      = 1'b1;
                enq_byte = NAK;
              end
            endcase
          end
        end
        P_ARGS: begin
          if (byte_valid_q) begin
            field_d   = (field_q << 8) | FW'(rx_shift_q);
            arg_cnt_d = arg_cnt_q + 3'd1;
            if (arg_cnt_d == need) p_state_d = P_EXEC;
          end
        end
        default: begin
          p_state_d = P_IDLE;
          enq       = 1'b1;
          enq_byte  = ACK;
          case (opcode_q)
            OP_SET_ADDR: ptr_d = field_q[ADDR_WIDTH-1:0];
            OP_WRITE: begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = field_q[DATA_WIDTH-1:0];
              ptr_d     = ptr_q + ADDR_WIDTH'(1);
            end
            OP_SET_STEP: step_d  = field_q[ADDR_WIDTH-1:0];
            default:     range_d = field_q[ADDR_WIDTH-1:0];
          endcase
        end
      endcase
    end

`ifdef LFSR_INIT_EN
    busy_d = init_active_q || (p_state_d != P_IDLE);
`else
    busy_d = (p_state_d != P_IDLE);
`endif

    // A slot freed by the transmitter this cycle can take a new response.
    deq          = (tx_state_q == TX_IDLE) && resp_valid_q;
    enq_ok       = enq && (!resp_valid_q || deq);
    resp_valid_d = enq_ok ? 1'b1 : (deq ? 1'b0 : resp_valid_q);
    resp_byte_d  = enq_ok ? enq_byte : resp_byte_q;

    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (deq) begin
      tx_state_d = TX_SEND;
      tx_shift_d = {1'b1, resp_byte_q, 1'b0};
      tx_bit_d   = '0;
      tx_cnt_d   = '0;
    end else if (tx_state_q == TX_SEND) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
        else                  tx_bit_d   = tx_bit_q + 4'd1;
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
    txd_d = (tx_state_d == TX_SEND) ? tx_shift_d[0] : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p_state_q    <= P_IDLE;
      opcode_q     <= '0;
      arg_cnt_q    <= '0;
      field_q      <= '0;
      ptr_q        <= '0;
      step_q       <= ADDR_WIDTH'(1);
      range_q      <= '1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_byte_q  <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '1;
      txd_q        <= 1'b1;
`ifdef LFSR_INIT_EN
      busy_q        <= 1'b1;
      init_active_q <= 1'b1;
      lfsr_q        <= 16'h0010;
`else
      busy_q       <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      p_state_q    <= p_state_d;
      opcode_q     <= opcode_d;
      arg_cnt_q    <= arg_cnt_d;
      field_q      <= field_d;
      ptr_q        <= ptr_d;
      step_q       <= step_d;
      range_q      <= range_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_byte_q  <= resp_byte_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
`ifdef LFSR_INIT_EN
      init_active_q <= init_active_d;
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign txd           = txd_q;
  assign busy          = busy_q;
  assign mem.wr_enable = wr_en_q;
  assign mem.wr_addr   = wr_addr_q;
  assign mem.wr_data   = wr_data_q;
  assign mem.step      = step_q;
  assign mem.range     = range_q;
endmodule
